rvh_l1d_ptw_req_arb: RTL

- Sequences page-table-walk (PTW) traffic into the L1D load pipeline port.
- Accepts one new walk request from the MMU and holds it until its response returns.
- Between issue and response, re-issues the same walk when the replay buffer requests a replay, which happens after a partial STB hit forces an eviction.
- Sits between the MMU PTW port, the PTW replay buffer and the L1D pipeline request port; counts replays per walk and flags runaway replay loops.

---
 rtl/rvh_l1d_ptw_req_arb_if.sv | 46 ++++
 rtl/rvh_l1d_ptw_req_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_ptw_req_arb_if.sv
// Handshake bundle between the PTW request arbiter and its MMU, replay buffer and L1D neighbours.
// Port names keep their original _i/_o affixes as seen from the arbiter.
interface rvh_l1d_ptw_req_arb_if #(
  parameter int unsigned PTW_ID_WIDTH = 4,
  parameter int unsigned PADDR_WIDTH  = 56
);
  logic                    ptw_walk_req_vld_i;
  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i;
  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i;
  logic                    ptw_walk_req_rdy_o;
  logic                    replay_req_vld_i;
  logic [PTW_ID_WIDTH-1:0] replay_req_id_i;
  logic [PADDR_WIDTH-1:0]  replay_req_paddr_i;
  logic                    replay_req_rdy_o;
  logic                    l1d_ptw_req_vld_o;
  logic [PTW_ID_WIDTH-1:0] l1d_ptw_req_id_o;
  logic [PADDR_WIDTH-1:0]  l1d_ptw_req_paddr_o;
  logic                    l1d_ptw_req_is_replay_o;
  logic                    l1d_ptw_req_rdy_i;
  logic                    ptw_walk_resp_vld_i;
  logic                    ptw_walk_resp_rdy_i;
  logic                    ptw_replay_ovf_o;
  logic                    ptw_walk_busy_o;

  modport slave (
    input  ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i,
    output ptw_walk_req_rdy_o,
    input  replay_req_vld_i, replay_req_id_i, replay_req_paddr_i,
    output replay_req_rdy_o,
    output l1d_ptw_req_vld_o, l1d_ptw_req_id_o, l1d_ptw_req_paddr_o, l1d_ptw_req_is_replay_o,
    input  l1d_ptw_req_rdy_i,
    input  ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i,
    output ptw_replay_ovf_o, ptw_walk_busy_o
  );

  modport master (
    output ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i,
    input  ptw_walk_req_rdy_o,
    output replay_req_vld_i, replay_req_id_i, replay_req_paddr_i,
    input  replay_req_rdy_o,
    input  l1d_ptw_req_vld_o, l1d_ptw_req_id_o, l1d_ptw_req_paddr_o, l1d_ptw_req_is_replay_o,
    output l1d_ptw_req_rdy_i,
    output ptw_walk_resp_vld_i, ptw_walk_resp_rdy_i,
    input  ptw_replay_ovf_o, ptw_walk_busy_o
  );
endinterface

// File: rtl/rvh_l1d_ptw_req_arb.sv
// Issues one outstanding PTW walk into the L1D load port and re-issues it on replay requests.
// Optional performance counters are enabled by defining RVH_L1D_PTW_ARB_PERF_EN.
module rvh_l1d_ptw_req_arb #(
  parameter int unsigned PTW_ID_WIDTH = 4,
  parameter int unsigned PADDR_WIDTH  = 56,
  parameter int unsigned MAX_REPLAY   = 8,
  parameter int unsigned RCNT_W       = $clog2(MAX_REPLAY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  rvh_l1d_ptw_req_arb_if.slave bus
`ifdef RVH_L1D_PTW_ARB_PERF_EN
  ,
  output logic [31:0]          perf_walk_cnt_o,
  output logic [31:0]          perf_replay_cnt_o,
  output logic [15:0]          perf_ovf_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPLAY} state_e;

  state_e                  state;
  logic                    vld_q;
  logic                    is_replay_q;
  logic                    ovf_q;
  logic [RCNT_W-1:0]       rcnt;
  logic [PTW_ID_WIDTH-1:0] id_q;
  logic [PADDR_WIDTH-1:0]  paddr_q;

  logic resp_hs;
  logic walk_acc;
  logic replay_acc;
  logic rcnt_sat;

  // A same-cycle response wins over a replay; the replay is simply not accepted.
  always_comb begin
    resp_hs    = bus.ptw_walk_resp_vld_i & bus.ptw_walk_resp_rdy_i;
    walk_acc   = (state == IDLE) & bus.ptw_walk_req_vld_i;
    replay_acc = (state == WAIT) & ~resp_hs & bus.replay_req_vld_i;
    rcnt_sat   = (rcnt == RCNT_W'(MAX_REPLAY));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      vld_q       <= 1'b0;
      is_replay_q <= 1'b0;
      ovf_q       <= 1'b0;
      rcnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (walk_acc) begin
            state       <= ISSUE;
            vld_q       <= 1'b1;
            is_replay_q <= 1'b0;
            ovf_q       <= 1'b0;
            rcnt        <= '0;
          end
        end
        ISSUE: begin
          if (bus.l1d_ptw_req_rdy_i) begin
            state <= WAIT;
            vld_q <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_hs) begin
            state <= IDLE;
          end else if (replay_acc) begin
            state       <= REPLAY;
            vld_q       <= 1'b1;
            is_replay_q <= 1'b1;
            if (rcnt_sat) ovf_q <= 1'b1;
            else          rcnt  <= rcnt + RCNT_W'(1);
          end
        end
        REPLAY: begin
          if (bus.l1d_ptw_req_rdy_i) begin
            state       <= WAIT;
            vld_q       <= 1'b0;
            is_replay_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload is not reset; it is only meaningful while vld_q is high.
  always_ff @(posedge clk) begin
    if (walk_acc) begin
      id_q    <= bus.ptw_walk_req_id_i;
      paddr_q <= bus.ptw_walk_req_addr_i;
    end else if (replay_acc) begin
      paddr_q <= bus.replay_req_paddr_i;
    end
  end

  assign bus.ptw_walk_req_rdy_o      = (state == IDLE);
  assign bus.replay_req_rdy_o        = (state == WAIT) & ~resp_hs;
  assign bus.l1d_ptw_req_vld_o       = vld_q;
  assign bus.l1d_ptw_req_id_o        = id_q;
  assign bus.l1d_ptw_req_paddr_o     = paddr_q;
  assign bus.l1d_ptw_req_is_replay_o = is_replay_q;
  assign bus.ptw_replay_ovf_o        = ovf_q;
  assign bus.ptw_walk_busy_o         = (state != IDLE);

`ifdef RVH_L1D_PTW_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_walk_cnt_o   <= '0;
      perf_replay_cnt_o <= '0;
      perf_ovf_cnt_o    <= '0;
    end else begin
      if (walk_acc)                        perf_walk_cnt_o   <= perf_walk_cnt_o + 32'd1;
      if (replay_acc)                      perf_replay_cnt_o <= perf_replay_cnt_o + 32'd1;
      if (replay_acc & rcnt_sat & ~ovf_q)  perf_ovf_cnt_o    <= perf_ovf_cnt_o + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic                    hold_q;
  logic [PTW_ID_WIDTH-1:0] id_h;
  logic [PADDR_WIDTH-1:0]  paddr_h;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 1'b0;
    end else begin
      hold_q  <= vld_q & ~bus.l1d_ptw_req_rdy_i;
      id_h    <= id_q;
      paddr_h <= paddr_q;
      assert (!(bus.ptw_walk_resp_vld_i && state != WAIT))
        else $fatal(1, "walk response outside WAIT state");
      assert (!(replay_acc && bus.replay_req_id_i != id_q))
        else $fatal(1, "replay id differs from held walk id");
      assert (!(hold_q && (id_q != id_h || paddr_q != paddr_h)))
        else $fatal(1, "request payload changed while stalled");
    end
  end
`endif

endmodule
